// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ requesters.
// A granted word (optionally preceded by a header byte carrying the requester
// index) is fed to the transmitter byte by byte, LSB first, using its
// strobe / idle-flag handshake.
module uart_tx_scheduler #(
    parameter int N_REQ     = 4,
    parameter int NB_WORD   = 32,
    parameter int NB_DATA   = 8,
    parameter int HEADER_EN = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*NB_WORD-1:0] i_data,
    output logic [N_REQ-1:0]         o_ack,
    output logic                     o_busy,
    output logic [NB_DATA-1:0]       o_tx_data,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready
);

    localparam int HDR      = (HEADER_EN != 0) ? 1 : 0;
    localparam int NB_WORDS = NB_WORD / NB_DATA;
    localparam int NB_BYTES = NB_WORDS + HDR;
    localparam int CNT_W    = $clog2(NB_BYTES + 1);
    localparam int IDX_W    = $clog2(N_REQ);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NB_BYTES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_LOW  = 3'd2,
        WAIT_HIGH = 3'd3,
        DONE      = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NB_WORD-1:0]   word_q, word_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 busy_q, busy_d;
    logic [N_REQ-1:0]     ack_q, ack_d;

    logic                 found;
    logic [IDX_W-1:0]     win;
    logic [NB_WORD-1:0]   grant_word;

    // Byte number cnt of a transfer: header (zero-extended index) first, then word bytes LSB first.
    function automatic logic [NB_DATA-1:0] pick_byte(
        input logic [NB_WORD-1:0] word,
        input logic [IDX_W-1:0]   idx,
        input logic [CNT_W-1:0]   cnt
    );
        logic [NB_DATA-1:0] b;
        b = '0;
        if (HDR != 0 && cnt == '0) begin
            b = NB_DATA'(idx);
        end else begin
            for (int i = 0; i < NB_WORDS; i++) begin
                if (cnt == CNT_W'(i + HDR)) b = word[i*NB_DATA +: NB_DATA];
            end
        end
        return b;
    endfunction

    // Round-robin arbitration: first requester found scanning upward from the pointer.
    always_comb begin
        int k;
        k          = 0;
        found      = 1'b0;
        win        = '0;
        grant_word = '0;
        for (int off = 0; off < N_REQ; off++) begin
            k = (int'(rr_q) + off) % N_REQ;
            if (!found && i_req[k]) begin
                found = 1'b1;
                win   = IDX_W'(k);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (win == IDX_W'(j)) grant_word = i_data[j*NB_WORD +: NB_WORD];
        end
    end

    // Next-state logic; registered outputs are derived from the next state.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        tx_data_d = tx_data_q;
        case (state_q)
            IDLE: begin
                if (found && i_tx_ready) begin
                    state_d   = SEND;
                    word_d    = grant_word;
                    idx_d     = win;
                    rr_d      = (win == LAST_IDX) ? '0 : win + 1'b1;
                    cnt_d     = '0;
                    tx_data_d = pick_byte(grant_word, win, '0);
                end
            end
            SEND: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                // The idle flag may still read high right after the strobe.
                if (!i_tx_ready) state_d = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (i_tx_ready) begin
                    if (cnt_q != LAST_CNT) begin
                        cnt_d     = cnt_q + 1'b1;
                        state_d   = SEND;
                        tx_data_d = pick_byte(word_q, idx_q, cnt_q + 1'b1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                tx_data_d = '0;
            end
        endcase

        tx_valid_d = (state_d == SEND);
        busy_d     = (state_d != IDLE);
        ack_d      = '0;
        if (state_d == DONE) ack_d[idx_d] = 1'b1;
    end

    // Control state and outputs, cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            cnt_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            ack_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
        end
    end

    // Latched word and granted index; only meaningful while a transfer is active.
    always_ff @(posedge i_clk) begin
        word_q <= word_d;
        idx_q  <= idx_d;
    end

    assign o_ack      = ack_q;
    assign o_busy     = busy_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_valid = tx_valid_q;

endmodule
